// File: rtl/irq_controller.sv
// Interrupt front end: NUM_IRQ maskable sources plus one NMI, ack/EOI handshake with the CPU.
// Define IRQ_ROTATE_PRIORITY_EN for rotating priority; default build uses fixed priority (index 0 highest).
module irq_controller #(
    parameter int unsigned          NUM_IRQ   = 8,
    parameter int unsigned          VEC_W     = 3,
    parameter logic [NUM_IRQ-1:0]   TRIG_EDGE = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               nmi_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               cpu_intd,
    input  logic               cpu_ina,
    input  logic               cpu_eoi,
    output logic               int_req,
    output logic               nmi_req,
    output logic [VEC_W-1:0]   vector,
    output logic               nmi_sel,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask,
    output logic               in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERV, NMI_SERV} state_t;

    state_t             state, state_nxt;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] pend_nxt;
    logic               nmi_q;
    logic               nmi_pend;
    logic               saved;
    logic [VEC_W-1:0]   vec_q;
    logic [VEC_W-1:0]   top;
    logic               found;
    logic               ack_irq;
    logic               ack_nmi;

    assign elig = pending & ~mask;

`ifdef IRQ_ROTATE_PRIORITY_EN
    logic [VEC_W-1:0] last;

    // Wrap-around search split in two passes: channels above last first, then the rest.
    always_comb begin
        top   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!found && (VEC_W'(i) > last) && elig[i]) begin
                top   = VEC_W'(i);
                found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!found && (VEC_W'(i) <= last) && elig[i]) begin
                top   = VEC_W'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= '0;
        end else if (ack_irq) begin
            last <= top;
        end
    end
`else
    always_comb begin
        top   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!found && elig[i]) begin
                top   = VEC_W'(i);
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        ack_irq   = 1'b0;
        nmi_req   = nmi_pend && (state != NMI_SERV);
        ack_nmi   = cpu_ina && nmi_req;
        // An NMI ack wins in every state it can occur in; a REQ it interrupts is simply dropped.
        if (ack_nmi) begin
            state_nxt = NMI_SERV;
        end else begin
            case (state)
                IDLE: begin
                    if ((elig != '0) && !cpu_intd) state_nxt = REQ;
                end
                REQ: begin
                    if ((elig == '0) || cpu_intd) begin
                        state_nxt = IDLE;
                    end else if (cpu_ina) begin
                        state_nxt = SERV;
                        ack_irq   = 1'b1;
                    end
                end
                SERV: begin
                    if (cpu_eoi) state_nxt = IDLE;
                end
                NMI_SERV: begin
                    if (cpu_eoi) state_nxt = saved ? SERV : IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        int_req    = (state == REQ);
        in_service = (state == SERV) || (state == NMI_SERV);
        nmi_sel    = nmi_req || (state == NMI_SERV);
        case (state)
            IDLE:    vector = '0;
            REQ:     vector = top;
            default: vector = vec_q;
        endcase
    end

    assign edge_det = irq_in & ~irq_q;
    assign pend_clr = ack_irq ? (NUM_IRQ'(1) << top) : '0;
    // Edge channels hold until acked (a new edge wins over the clear); level channels follow the source.
    assign pend_nxt = (TRIG_EDGE & (edge_det | (pending & ~pend_clr))) | (~TRIG_EDGE & irq_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pending  <= '0;
            mask     <= '1;
            irq_q    <= '0;
            nmi_q    <= 1'b0;
            nmi_pend <= 1'b0;
            saved    <= 1'b0;
            vec_q    <= '0;
        end else begin
            state    <= state_nxt;
            pending  <= pend_nxt;
            irq_q    <= irq_in;
            nmi_q    <= nmi_in;
            nmi_pend <= (nmi_in & ~nmi_q) | (nmi_pend & ~ack_nmi);
            if (mask_we) mask <= mask_wdata;
            if (ack_irq) vec_q <= top;
            if (ack_nmi) begin
                saved <= (state == SERV);
            end else if ((state == NMI_SERV) && cpu_eoi) begin
                saved <= 1'b0;
            end
        end
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised interrupt front end for the multicycle MIPS core.
- Collects NUM_IRQ maskable sources plus one NMI, latches them as pending and prioritises them.
- Drives INT/NMI-style requests to the controller and completes an acknowledge/end-of-interrupt handshake with it.
- Successor to the single-line INT/NMI/INTD/INA scheme: generalised channel count, per-channel edge/level trigger, mask register, vector output, one level of NMI-over-IRQ nesting.

Parameters:
- NUM_IRQ, 8, number of maskable sources (2..32).
- VEC_W, 3, vector width; must equal clog2(NUM_IRQ).
- TRIG_EDGE, 8'hFF, per-channel trigger mode; bit i=1 means rising-edge, 0 means level-high.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  NUM_IRQ  raw interrupt sources, synchronous to clk.
- nmi_in  in  1  non-maskable source, rising-edge triggered.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NUM_IRQ  new mask value; bit=1 blocks the channel.
- cpu_intd  in  1  CPU global interrupt disable; gates maskable requests only.
- cpu_ina  in  1  acknowledge pulse from CPU, one cycle.
- cpu_eoi  in  1  end-of-interrupt pulse from CPU, one cycle.
- int_req  out  1  maskable interrupt request to CPU.
- nmi_req  out  1  NMI request to CPU.
- vector  out  VEC_W  index of the requesting/serviced channel.
- nmi_sel  out  1  1 means the current request or service is the NMI.
- pending  out  NUM_IRQ  pending register.
- mask  out  NUM_IRQ  mask register.
- in_service  out  1  high while in SERV or NMI_SERV.

Behaviour:
- Reset (synchronous, active-high, clk domain only):
  - state=IDLE; pending=0; irq_q=0; nmi_q=0; nmi_pend=0; saved=0.
  - mask=all ones.
  - int_req=0, nmi_req=0, vector=0, nmi_sel=0, in_service=0.
  - Reset mid-service drops everything with no EOI needed.
  - A source already high when reset releases counts as an edge (irq_q reset to 0).
- Edge detection:
  - irq_q<=irq_in each cycle; edge_i = irq_in[i] & ~irq_q[i].
  - Edge channel: pending[i] set on edge_i; cleared only when that channel is acknowledged.
  - Level channel: pending[i] <= irq_in[i] every cycle; not cleared by ack; the source must drop before cpu_eoi.
  - Set and clear in the same cycle on the same channel: set wins.
- Eligibility and priority:
  - elig = pending & ~mask.
  - Fixed priority, lowest index highest.
  - mask_we updates mask at the clock edge; the new value takes effect the following cycle.
- Latency: irq_in rise seen at edge n -> pending visible n+1 -> int_req high n+2.
- FSM states: IDLE, REQ, SERV, NMI_SERV.
  - IDLE -> REQ when elig!=0 and ~cpu_intd.
  - REQ:
    - int_req=1; vector tracks the current top-priority eligible channel.
    - cpu_ina (and no nmi_req) -> SERV; vector latched; edge pending bit cleared; int_req=0.
    - elig becomes 0 or cpu_intd=1 -> IDLE (request withdrawn, no ack needed).
  - SERV:
    - in_service=1; vector held.
    - cpu_eoi -> IDLE. New requests re-arbitrate from IDLE.
  - NMI_SERV:
    - in_service=1; nmi_sel=1.
    - cpu_eoi -> SERV if saved=1 (restore latched vector), else IDLE; saved cleared.
- NMI:
  - nmi_pend set on an nmi_in rising edge; set wins over a same-cycle clear.
  - nmi_req = nmi_pend & (state!=NMI_SERV).
  - NMI ignores mask and cpu_intd.
  - cpu_ina while nmi_req=1 always acknowledges the NMI, even in REQ:
    - nmi_pend cleared; nmi_sel=1.
    - saved=1 if the previous state was SERV.
    - Goes to NMI_SERV. A REQ interrupted this way is dropped; its pending bit stays set.
  - NMI edge during NMI_SERV stays pending; nmi_req rises the cycle after leaving NMI_SERV.
- cpu_ina in IDLE/SERV with no nmi_req: ignored.
- cpu_eoi outside SERV/NMI_SERV: ignored.

Optional Feature:
- Macro IRQ_ROTATE_PRIORITY_EN.
- Defined: rotating priority. A last-serviced register (reset 0) updates on each maskable ack. Search starts at (last+1) mod NUM_IRQ with wrap-around; the highest-priority channel is the one after the last serviced.
- Undefined: fixed priority, index 0 highest; no rotation register is built.
- NMI behaviour is identical either way.

Test Plan:
- Reset; mask_wdata=8'h00 written; irq_in[5] rises at cycle 10 -> pending[5]=1 at cycle 11; int_req=1, vector=5 at cycle 12; cpu_ina -> in_service=1, pending[5]=0; cpu_eoi -> IDLE.
- irq_in[2] and irq_in[6] rise together -> vector=2 served first; after eoi, vector=6. With IRQ_ROTATE_PRIORITY_EN and last=2, a simultaneous 2+6 request -> vector=6.
- Mask bit 3=1, irq_in[3] pulses -> pending[3]=1, int_req stays 0; clear mask -> int_req=1 two cycles later. cpu_intd=1 in REQ -> int_req drops next cycle.
- In SERV with vector=4, nmi_in rises -> nmi_req=1; cpu_ina -> NMI_SERV, nmi_sel=1; cpu_eoi -> SERV, vector=4; second eoi -> IDLE.
- Level channel (TRIG_EDGE bit 1=0) held high through ack -> pending[1] stays 1; source drops, then eoi -> no re-request.
- Reset asserted in NMI_SERV -> next cycle all outputs 0, mask=all ones.
